timer_input_capture: RTL and testbench

Input-capture companion to the basic prescaled timer.
- Measures external events instead of generating them: a prescaled, free-running up-counter whose value is latched on a selected edge of an asynchronous input pin.
- Includes a synchronizer, a digital glitch filter, pending/over-capture status and interrupt pulses.
- Sits beside the basic timer in the SoC peripheral set; register-interface logic drives its control inputs.

---
 rtl/timer_input_capture.sv | 176 +++++++++++++++++
 tb/tb_timer_input_capture.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_input_capture.sv
// timer_input_capture: prescaled free-running up-counter whose value is
// latched on a selected edge of an asynchronous input pin, with a 2-flop
// synchronizer, a programmable digital glitch filter, pending/overrun
// status and single-cycle capture / overflow interrupt pulses.
//
// Optional build macro: TIMER_CAP_RESET_ON_CAPTURE_EN
//   defined   - each capture clears counter and prescaler, so cap_v reads
//               the period/width in ticks directly (cnt_to_set still wins).
//   undefined - counter is free-running; software subtracts captures.
module timer_input_capture #(
  parameter int timer_width      = 16,
  parameter int simulation_delay = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [timer_width-1:0] prescale,
  input  logic                   cap_en,
  input  logic [1:0]             edge_mode,
  input  logic [3:0]             filter_th,
  input  logic                   cnt_to_set,
  input  logic [timer_width-1:0] cnt_set_v,
  output logic [timer_width-1:0] cnt_now_v,
  input  logic                   cap_in,
  output logic [timer_width-1:0] cap_v,
  output logic                   cap_pending,
  output logic                   cap_overrun,
  input  logic                   cap_rd,
  output logic                   cap_itr_req,
  output logic                   ovf_itr_req
);

  // Sequential assignments carry no delay in this version; the parameter
  // is kept so existing instantiations still elaborate unchanged.
  logic sim_delay_unused;
  assign sim_delay_unused = (simulation_delay != 0);

  logic                   cap_s1;
  logic                   cap_s2;
  logic                   filt_lvl;
  logic                   filt_lvl_d;
  logic [3:0]             fcnt;
  logic                   edge_stb;
  logic                   capture;
  logic [timer_width-1:0] psc_cnt;
  logic [timer_width-1:0] psc_shadow;
  logic                   psc_tick;
  logic [timer_width-1:0] cnt;
  logic [timer_width-1:0] cnt_next;
  logic                   cnt_wrap;
  logic                   cap_fire;
  logic                   ovf_fire;

  assign cnt_now_v = cnt;
  assign psc_tick  = (psc_cnt == psc_shadow);
  assign capture   = edge_stb & cap_en;

  // Two-flop synchronizer for the asynchronous capture pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_s1 <= 1'b0;
      cap_s2 <= 1'b0;
    end else begin
      cap_s1 <= cap_in;
      cap_s2 <= cap_s1;
    end
  end

  // Glitch filter: level must differ for filter_th+1 consecutive cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_lvl   <= 1'b0;
      filt_lvl_d <= 1'b0;
      fcnt       <= '0;
    end else begin
      filt_lvl_d <= filt_lvl;
      if (cap_s2 != filt_lvl) begin
        if (fcnt == filter_th) begin
          filt_lvl <= cap_s2;
          fcnt     <= '0;
        end else begin
          fcnt <= fcnt + 4'd1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  // Edge strobe on the filtered level, qualified by the selected mode.
  always_comb begin
    edge_stb = 1'b0;
    case (edge_mode)
      2'b01:   edge_stb = ~filt_lvl & filt_lvl_d;
      2'b10:   edge_stb = filt_lvl ^ filt_lvl_d;
      default: edge_stb = filt_lvl & ~filt_lvl_d;
    endcase
  end

  // Prescaler: shadow ratio reloads while disabled or at each tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      psc_cnt    <= '0;
      psc_shadow <= '0;
    end else if (!cap_en) begin
      psc_cnt    <= '0;
      psc_shadow <= prescale;
`ifdef TIMER_CAP_RESET_ON_CAPTURE_EN
    end else if (capture) begin
      psc_cnt <= '0;
`endif
    end else if (psc_tick) begin
      psc_cnt    <= '0;
      psc_shadow <= prescale;
    end else begin
      psc_cnt <= psc_cnt + 1'b1;
    end
  end

  // Counter next value: load beats capture-clear beats increment.
  always_comb begin
    cnt_next = cnt;
    cnt_wrap = 1'b0;
    if (cnt_to_set) begin
      cnt_next = cnt_set_v;
`ifdef TIMER_CAP_RESET_ON_CAPTURE_EN
    end else if (capture) begin
      cnt_next = '0;
`endif
    end else if (cap_en && psc_tick) begin
      cnt_next = cnt + 1'b1;
      cnt_wrap = (cnt == '1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  // Capture register and status; a read coinciding with a capture consumes
  // the old value, so overrun only reflects an unread value being lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_v       <= '0;
      cap_pending <= 1'b0;
      cap_overrun <= 1'b0;
    end else if (capture) begin
      cap_v       <= cnt;
      cap_pending <= 1'b1;
      cap_overrun <= cap_pending & ~cap_rd;
    end else if (cap_rd) begin
      cap_pending <= 1'b0;
      cap_overrun <= 1'b0;
    end
  end

  // Interrupt pulses, registered one cycle after the causing event.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_fire    <= 1'b0;
      ovf_fire    <= 1'b0;
      cap_itr_req <= 1'b0;
      ovf_itr_req <= 1'b0;
    end else begin
      cap_fire    <= capture;
      ovf_fire    <= cnt_wrap;
      cap_itr_req <= cap_fire;
      ovf_itr_req <= ovf_fire;
    end
  end

endmodule

// File: tb/tb_timer_input_capture.sv
// Self-checking bench for timer_input_capture: table of edge/filter cases
// plus hand-written reset, read/capture collision, period and overflow
// sequences. Expected capture values go into a queue when the pin is
// driven and are compared whenever cap_itr_req pulses.
module tb_timer_input_capture;

  localparam int TW = 16;
  localparam int NV = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [TW-1:0] prescale;
  logic          cap_en;
  logic [1:0]    edge_mode;
  logic [3:0]    filter_th;
  logic          cnt_to_set;
  logic [TW-1:0] cnt_set_v;
  logic [TW-1:0] cnt_now_v;
  logic          cap_in;
  logic [TW-1:0] cap_v;
  logic          cap_pending;
  logic          cap_overrun;
  logic          cap_rd;
  logic          cap_itr_req;
  logic          ovf_itr_req;

  always #5 clk = ~clk;

  timer_input_capture #(
    .timer_width(TW),
    .simulation_delay(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .prescale(prescale),
    .cap_en(cap_en),
    .edge_mode(edge_mode),
    .filter_th(filter_th),
    .cnt_to_set(cnt_to_set),
    .cnt_set_v(cnt_set_v),
    .cnt_now_v(cnt_now_v),
    .cap_in(cap_in),
    .cap_v(cap_v),
    .cap_pending(cap_pending),
    .cap_overrun(cap_overrun),
    .cap_rd(cap_rd),
    .cap_itr_req(cap_itr_req),
    .ovf_itr_req(ovf_itr_req)
  );

  typedef struct {
    logic [1:0] mode;
    logic [3:0] th;
    int         width;
    bit         rise;
    bit         fall;
  } vec_t;

  vec_t          vecs[NV];
  logic [TW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            ncap = 0;

  // Posedge index, read at negedges to compute capture cycles.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected cap_v for a capture at posedge r, counter loaded with v at
  // posedge p0 and ticking every cycle since; prev_r is the previous
  // capture posedge after that load (0 if none).
  function automatic logic [TW-1:0] exp_cap(input int v, input int p0, input int r, input int prev_r);
`ifdef TIMER_CAP_RESET_ON_CAPTURE_EN
    if (prev_r != 0) return TW'(r - prev_r - 1);
`endif
    return TW'(v + r - 1 - p0);
  endfunction

  // Scoreboard consumer: each capture interrupt pops one expected value.
  always @(negedge clk) begin
    logic [TW-1:0] e;
    if (!rst && cap_itr_req) begin
      ncap++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_capture cap_v=%0h expected no capture (t=%0t)", cap_v, $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_cap_v", cap_v, e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int k, p0, v, r, prev;
    logic [TW-1:0] e3;
    int n0;

    vecs[0] = '{mode: 2'b00, th: 4'd0,  width: 5,  rise: 1'b1, fall: 1'b0};
    vecs[1] = '{mode: 2'b01, th: 4'd0,  width: 5,  rise: 1'b0, fall: 1'b1};
    vecs[2] = '{mode: 2'b10, th: 4'd0,  width: 20, rise: 1'b1, fall: 1'b1};
    vecs[3] = '{mode: 2'b11, th: 4'd0,  width: 5,  rise: 1'b1, fall: 1'b0};
    vecs[4] = '{mode: 2'b00, th: 4'd4,  width: 3,  rise: 1'b0, fall: 1'b0};
    vecs[5] = '{mode: 2'b00, th: 4'd4,  width: 6,  rise: 1'b1, fall: 1'b0};
    vecs[6] = '{mode: 2'b00, th: 4'd4,  width: 5,  rise: 1'b1, fall: 1'b0};
    vecs[7] = '{mode: 2'b00, th: 4'd4,  width: 4,  rise: 1'b0, fall: 1'b0};
    vecs[8] = '{mode: 2'b10, th: 4'd15, width: 16, rise: 1'b1, fall: 1'b1};
    vecs[9] = '{mode: 2'b00, th: 4'd2,  width: 1,  rise: 1'b0, fall: 1'b0};

    // Reset with the pin already high: one rising capture 3 clk after reset.
    rst = 1'b1; cap_in = 1'b1; cap_en = 1'b1; prescale = '0; edge_mode = 2'b00;
    filter_th = 4'd0; cnt_to_set = 1'b0; cnt_set_v = '0; cap_rd = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cnt", cnt_now_v, 0);
    check("rst_cap_v", cap_v, 0);
    check("rst_pending", cap_pending, 0);
    check("rst_overrun", cap_overrun, 0);
    check("rst_cap_irq", cap_itr_req, 0);
    check("rst_ovf_irq", ovf_itr_req, 0);
    rst = 1'b0;
    exp_q.push_back(TW'(3));
    repeat (3) @(negedge clk);
    check("rst_edge_early", cap_pending, 0);
    @(negedge clk);
    check("rst_edge_pending", cap_pending, 1);
    check("rst_edge_cap_v", cap_v, 3);
    check("rst_edge_irq_early", cap_itr_req, 0);
    @(negedge clk);
    check("rst_edge_irq", cap_itr_req, 1);
    @(negedge clk);
    check("rst_edge_irq_end", cap_itr_req, 0);
    cap_rd = 1'b1; cap_in = 1'b0;
    @(negedge clk);
    cap_rd = 1'b0;
    check("rst_edge_rd", cap_pending, 0);
    repeat (6) @(negedge clk);

    // Edge-mode / filter table.
    for (int i = 0; i < NV; i++) begin
      v = 'h100 * (i + 1);
      @(negedge clk);
      cap_en = 1'b0; prescale = '0; cnt_to_set = 1'b1; cnt_set_v = TW'(v);
      edge_mode = vecs[i].mode; filter_th = vecs[i].th;
      @(negedge clk);
      p0 = cyc; cnt_to_set = 1'b0; cap_en = 1'b1; n0 = ncap;
      @(negedge clk);
      k = cyc + 1; cap_in = 1'b1;
      prev = 0;
      if (vecs[i].rise) begin
        r = k + 3 + int'(vecs[i].th);
        exp_q.push_back(exp_cap(v, p0, r, 0));
        prev = r;
      end
      if (vecs[i].fall) begin
        r = k + vecs[i].width + 3 + int'(vecs[i].th);
        exp_q.push_back(exp_cap(v, p0, r, prev));
      end
      repeat (vecs[i].width) @(negedge clk);
      cap_in = 1'b0;
      repeat (int'(vecs[i].th) + 8) @(negedge clk);
      check($sformatf("v%0d_ncap", i), ncap - n0, int'(vecs[i].rise) + int'(vecs[i].fall));
      check($sformatf("v%0d_pending", i), cap_pending, vecs[i].rise | vecs[i].fall);
      check($sformatf("v%0d_overrun", i), cap_overrun, vecs[i].rise & vecs[i].fall);
      cap_rd = 1'b1;
      @(negedge clk);
      cap_rd = 1'b0;
      check($sformatf("v%0d_rd_pending", i), cap_pending, 0);
      check($sformatf("v%0d_rd_overrun", i), cap_overrun, 0);
    end

    // Overrun, then a capture colliding with cap_rd, then edges while disabled.
    v = 'h2000;
    @(negedge clk);
    cap_en = 1'b0; edge_mode = 2'b10; filter_th = 4'd0; cnt_to_set = 1'b1; cnt_set_v = TW'(v);
    @(negedge clk);
    p0 = cyc; cnt_to_set = 1'b0; cap_en = 1'b1;
    @(negedge clk);
    k = cyc + 1; cap_in = 1'b1;
    exp_q.push_back(exp_cap(v, p0, k + 3, 0));
    repeat (10) @(negedge clk);
    cap_in = 1'b0;
    exp_q.push_back(exp_cap(v, p0, k + 13, k + 3));
    repeat (10) @(negedge clk);
    cap_in = 1'b1;
    e3 = exp_cap(v, p0, k + 23, k + 13);
    exp_q.push_back(e3);
    repeat (3) @(negedge clk);
    check("col_pre_pending", cap_pending, 1);
    check("col_pre_overrun", cap_overrun, 1);
    cap_rd = 1'b1;
    @(negedge clk);
    cap_rd = 1'b0;
    check("col_pending", cap_pending, 1);
    check("col_overrun", cap_overrun, 0);
    check("col_cap_v", cap_v, e3);
    @(negedge clk);
    cap_rd = 1'b1;
    @(negedge clk);
    cap_rd = 1'b0;
    check("col_rd_pending", cap_pending, 0);
    check("col_rd_overrun", cap_overrun, 0);
    cap_en = 1'b0; cap_in = 1'b0; n0 = ncap;
    repeat (8) @(negedge clk);
    check("dis_ncap", ncap - n0, 0);
    check("dis_pending", cap_pending, 0);

    // Rising edges every 50 clk.
    v = 0;
    @(negedge clk);
    cap_en = 1'b0; edge_mode = 2'b00; cnt_to_set = 1'b1; cnt_set_v = '0;
    @(negedge clk);
    p0 = cyc; cnt_to_set = 1'b0; cap_en = 1'b1;
    prev = 0;
    for (int e = 0; e < 3; e++) begin
      @(negedge clk);
      k = cyc + 1; cap_in = 1'b1; r = k + 3;
      exp_q.push_back(exp_cap(v, p0, r, prev));
      repeat (4) @(negedge clk);
`ifdef TIMER_CAP_RESET_ON_CAPTURE_EN
      check($sformatf("per%0d_cnt", e), cnt_now_v, 0);
`else
      check($sformatf("per%0d_cnt", e), cnt_now_v, TW'(v + r - p0));
`endif
      prev = r;
      repeat (21) @(negedge clk);
      cap_in = 1'b0;
      repeat (24) @(negedge clk);
    end
    cap_rd = 1'b1;
    @(negedge clk);
    cap_rd = 1'b0;

    // Prescale 3 from 0xFFFE: 0xFFFF after 4 clk, wrap after 8, one ovf pulse.
    @(negedge clk);
    cap_en = 1'b0; prescale = TW'(3); cnt_to_set = 1'b1; cnt_set_v = 16'hFFFE;
    @(negedge clk);
    cnt_to_set = 1'b0; cap_en = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j < 4)       check($sformatf("ovf_cnt%0d", j), cnt_now_v, 16'hFFFE);
      else if (j < 8)  check($sformatf("ovf_cnt%0d", j), cnt_now_v, 16'hFFFF);
      else if (j < 12) check($sformatf("ovf_cnt%0d", j), cnt_now_v, 16'h0000);
      else             check($sformatf("ovf_cnt%0d", j), cnt_now_v, 16'h0001);
      check($sformatf("ovf_irq%0d", j), ovf_itr_req, (j == 9));
    end

    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
